// File: rtl/cl_st_unpack_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : cl_st_unpack_pkg                                              |
// | Brief    : Shared constants, FSM encoding and CL-count helper for the    |
// |            cache-line to stream-symbol unpacker.                         |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package cl_st_unpack_pkg;

  localparam int CL         = 512;
  localparam int CL_HEAD    = 16;
  localparam int CL_PAYLOAD = CL - CL_HEAD;
  localparam int W_ST       = 62;
  localparam int N_ST       = CL_PAYLOAD / W_ST;
  localparam int W_NUM_ST   = 16;
  localparam int W_ST_IDX   = $clog2(N_ST + 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_OUT  = 3'd3,
    ST_FIN  = 3'd4
  } state_t;

  // Number of cache lines needed to carry len stream symbols.
  function automatic logic [W_NUM_ST-1:0] ceil_div_nst(input logic [W_NUM_ST-1:0] len);
    logic [W_NUM_ST:0] sum;
    sum = {1'b0, len} + (W_NUM_ST + 1)'(N_ST - 1);
    return W_NUM_ST'(sum / (W_NUM_ST + 1)'(N_ST));
  endfunction

endpackage
`default_nettype wire

// File: rtl/cl_st_unpack.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : cl_st_unpack                                                  |
// | Brief    : Reads one framed burst of cache lines, strips the CL head and |
// |            serialises payloads into sop/eop-framed stream symbols.       |
// |            Optional macro CL_ST_UNPACK_PREFETCH_EN adds a one-CL         |
// |            prefetch register for bubble-free output.                     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module cl_st_unpack
  import cl_st_unpack_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ff_rd_ready,
  output logic                ff_rdreq,
  input  logic [CL-1:0]       ff_q,
  output logic                ff_rd_finish,
  input  logic [W_NUM_ST-1:0] sb_len,
  output logic [W_ST-1:0]     source_data,
  output logic                source_valid,
  input  logic                source_ready,
  output logic                source_sop,
  output logic                source_eop
);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [W_NUM_ST-1:0]     r_st_left;
  logic [W_NUM_ST-1:0]     r_cl_left;
  logic [W_ST_IDX-1:0]     r_st_idx;
  logic [CL_PAYLOAD-1:0]   r_shift;
  logic                    r_first;
  logic                    r_holdoff;

  logic                    w_start;
  logic                    w_accept;
  logic                    w_last;
  logic                    w_wrap;
  logic                    w_pf_req;
  logic                    w_pf_hit;
  logic [CL_PAYLOAD-1:0]   w_pf_payload;
  logic                    w_unused_head;

  assign w_unused_head = ^ff_q[CL-1:CL_PAYLOAD];

  assign w_start  = (r_state == ST_IDLE) && ff_rd_ready && !r_holdoff;
  assign w_accept = (r_state == ST_OUT) && source_ready;
  assign w_last   = w_accept && (r_st_left == W_NUM_ST'(1));
  assign w_wrap   = w_accept && (r_st_idx == W_ST_IDX'(N_ST - 1));

`ifdef CL_ST_UNPACK_PREFETCH_EN
  logic [CL_PAYLOAD-1:0] r_pf_data;
  logic                  r_pf_valid;
  logic                  r_pf_inflight;

  assign w_pf_req     = (r_state == ST_OUT) && (r_cl_left != '0) &&
                        !r_pf_valid && !r_pf_inflight;
  assign w_pf_hit     = r_pf_valid || r_pf_inflight;
  // A read still in flight at wrap time is forwarded straight from the FIFO.
  assign w_pf_payload = r_pf_valid ? r_pf_data : ff_q[CL_PAYLOAD-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pf_data     <= '0;
      r_pf_valid    <= 1'b0;
      r_pf_inflight <= 1'b0;
    end else if (r_state == ST_FIN) begin
      r_pf_valid    <= 1'b0;
      r_pf_inflight <= 1'b0;
    end else begin
      r_pf_inflight <= w_pf_req;
      if (r_pf_inflight && !w_wrap) begin
        r_pf_data  <= ff_q[CL_PAYLOAD-1:0];
        r_pf_valid <= 1'b1;
      end else if (w_wrap && r_pf_valid) begin
        r_pf_valid <= 1'b0;
      end
    end
  end
`else
  assign w_pf_req     = 1'b0;
  assign w_pf_hit     = 1'b0;
  assign w_pf_payload = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    ff_rdreq     = 1'b0;
    ff_rd_finish = 1'b0;
    source_valid = 1'b0;
    source_sop   = 1'b0;
    source_eop   = 1'b0;
    source_data  = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_nxt = (sb_len == '0) ? ST_FIN : ST_REQ;
        end
      end
      ST_REQ: begin
        ff_rdreq    = 1'b1;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        w_state_nxt = ST_OUT;
      end
      ST_OUT: begin
        source_valid = 1'b1;
        source_data  = r_shift[W_ST-1:0];
        source_sop   = r_first;
        source_eop   = (r_st_left == W_NUM_ST'(1));
        ff_rdreq     = w_pf_req;
        if (w_last) begin
          w_state_nxt = ST_FIN;
        end else if (w_wrap && !w_pf_hit) begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_FIN: begin
        ff_rd_finish = 1'b1;
        w_state_nxt  = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Payload is shifted right so the current symbol always sits at the LSBs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st_left <= '0;
      r_cl_left <= '0;
      r_st_idx  <= '0;
      r_shift   <= '0;
      r_first   <= 1'b0;
      r_holdoff <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_holdoff <= 1'b0;
          if (w_start) begin
            r_st_left <= sb_len;
            r_cl_left <= ceil_div_nst(sb_len);
            r_first   <= 1'b1;
          end
        end
        ST_REQ: begin
          r_cl_left <= r_cl_left - W_NUM_ST'(1);
        end
        ST_WAIT: begin
          r_shift  <= ff_q[CL_PAYLOAD-1:0];
          r_st_idx <= '0;
        end
        ST_OUT: begin
          if (w_pf_req) begin
            r_cl_left <= r_cl_left - W_NUM_ST'(1);
          end
          if (w_accept) begin
            r_first   <= 1'b0;
            r_st_left <= r_st_left - W_NUM_ST'(1);
            if (w_wrap && w_pf_hit) begin
              r_shift  <= w_pf_payload;
              r_st_idx <= '0;
            end else begin
              r_shift  <= r_shift >> W_ST;
              r_st_idx <= r_st_idx + W_ST_IDX'(1);
            end
          end
        end
        ST_FIN: begin
          r_holdoff <= 1'b1;
          r_st_idx  <= '0;
        end
        default: begin
          r_holdoff <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/cl_st_unpack.md
# cl_st_unpack

Downstream stage of the pre-AFU cache-line buffer. It waits until the buffer signals that a complete AFU frame is stored, then reads the frame's cache lines (CLs) out of the FIFO. It strips the 16-bit CL head and serialises each 496-bit payload into W_ST-bit stream symbols (STs) with sop/eop framing. It emits exactly sb_len STs, then pulses ff_rd_finish to release the buffer for the next frame.

## Interface
- CL, 512: cache-line width.
- CL_HEAD, 16: head field width, located at bits [CL-1:CL-CL_HEAD].
- CL_PAYLOAD, 496: payload width, located at bits [CL_PAYLOAD-1:0].
- W_ST, 62: ST width. CL_PAYLOAD must be an integer multiple of W_ST; N_ST = CL_PAYLOAD/W_ST = 8.
- w_NumOfST_in_AFUFrm, 16: width of the frame-length field.
- clk  in  1  single clock for the whole block.
- rst_n  in  1  reset, asynchronous, active-low.
- ff_rd_ready  in  1  buffer holds one complete frame (level).
- ff_rdreq  out  1  FIFO read request. ff_q is valid in the cycle after ff_rdreq.
- ff_q  in  CL  FIFO read data.
- ff_rd_finish  out  1  one-cycle pulse: frame fully read.
- sb_len  in  w_NumOfST_in_AFUFrm  frame length in STs, valid while ff_rd_ready=1.
- source_data  out  W_ST  ST output.
- source_valid  out  1  ST valid.
- source_ready  in  1  downstream accept.
- source_sop  out  1  first ST of the frame.
- source_eop  out  1  last ST of the frame.

## Operation
- FSM states: IDLE, REQ, WAIT, OUT, FIN.
- IDLE:
  - Transition requires ff_rd_ready=1 and the block not being in its holdoff cycle (see FIN).
  - Latch len=sb_len and cl_left=ceil(len/N_ST).
  - If len=0, go to FIN; no ff_rdreq is issued. Otherwise go to REQ.
- REQ: assert ff_rdreq for exactly one cycle, decrement cl_left, go to WAIT.
- WAIT: capture ff_q payload into the shift register, set st_idx=0, go to OUT.
- OUT:
  - source_data = payload[st_idx*W_ST +: W_ST]. ST 0 is the payload LSBs.
  - On source_valid && source_ready: increment st_idx and decrement st_left.
  - When st_left reaches 0, go to FIN. Unused STs in the last CL are discarded.
  - Else, when st_idx reaches N_ST, go to REQ, or load from the prefetch register (see Configuration).
- FIN: ff_rd_finish=1 for one cycle, then go to IDLE. ff_rd_ready is ignored during the IDLE cycle immediately after FIN (holdoff), so upstream has time to deassert it.
- source_sop is high on the first ST of a frame. source_eop is high when st_left=1. For len=1, sop and eop are both high on the same ST.
- AXI-style hold: once source_valid is asserted, source_valid and all data/flags stay stable until accepted.
- The CL head is ignored; frame length comes only from sb_len.
- Total CL reads per frame equal ceil(len/N_ST), no more.

## Timing
- Reset values: ff_rdreq=0, ff_rd_finish=0, source_valid=0, source_sop=0, source_eop=0, source_data=0. FSM in IDLE, all counters 0.
- Asserting rst_n mid-frame abandons the frame immediately; no ff_rd_finish is issued. The upstream buffer is cleared by its own reset.
- Latency, source_ready tied high:
  - ff_rd_ready sampled in IDLE at cycle 0.
  - ff_rdreq in cycle 1.
  - Capture in cycle 2.
  - First source_valid in cycle 3.
- Without prefetch: 2 idle cycles between CLs.
- After the last accepted ST: ff_rd_finish in the next cycle. The earliest next IDLE start is 2 cycles after the finish pulse.
- Backpressure (source_ready=0) stalls only OUT. The REQ/WAIT sequence is never interrupted.

## Configuration
- CL_ST_UNPACK_PREFETCH_EN defined:
  - Adds one CL prefetch register with a valid flag.
  - In OUT, issue ff_rdreq when cl_left>0, the prefetch register is empty, and no read is in flight. Capture ff_q one cycle later.
  - On st_idx wrap, load the shift register from the prefetch register with no bubble, giving sustained 1 ST/cycle.
  - The prefetch register is cleared in FIN and on reset.
- Not defined: the behaviour described in Operation, with 2-cycle bubbles between CLs.
- Both builds produce identical ST sequences; only cycle counts differ.

## Structure
- Shared package holds:
  - Constants CL, CL_HEAD, CL_PAYLOAD, W_ST, N_ST.
  - FSM state encoding.
  - Helper for ceil(len/N_ST).
- No sub-module is required. The optional prefetch register is kept inline.

## Test plan
- len=8, source_ready=1, payload STs 0..7 = 0x1..0x8:
  - Exactly 1 ff_rdreq; outputs 0x1..0x8.
  - sop on 0x1, eop on 0x8.
  - ff_rd_finish one cycle after 0x8.
  - First valid 3 cycles after ff_rd_ready.
- len=11:
  - 2 reads; STs 0..7 of CL0, then STs 0..2 of CL1; eop on the 11th ST.
  - 5 unused STs dropped.
  - Without prefetch: 2-cycle gap between CLs. With prefetch: no gap.
- len=0: no ff_rdreq, no source_valid, ff_rd_finish 1 cycle after ff_rd_ready is sampled.
- len=1: single ST with sop=eop=1, one read.
- Random source_ready at 50% on len=20: data and flags stable while stalled; 3 reads; exact ST order preserved.
- Reset asserted mid-frame at ST 4 of len=16:
  - All outputs return to 0 asynchronously; no finish pulse.
  - After release, a new len=8 frame is processed correctly.
